// File: rtl/apb_program_loader.sv
// APB initiator that streams a program image into the core's instruction memory,
// then releases the core. Optional read-back verify: define LOADER_READBACK_EN.
module apb_program_loader #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 32,
  parameter int ACCESS_CYCLES  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDRESS_LENGTH-1:0] base_addr,
  input  logic [15:0]               word_count,
  input  logic                      s_valid,
  input  logic [DATA_LENGTH-1:0]    s_data,
  output logic                      s_ready,
  output logic [ADDRESS_LENGTH-1:0] paddr,
  output logic [DATA_LENGTH-1:0]    pwdata,
  output logic                      pselect,
  output logic                      pwrite,
  output logic                      pready,
  input  logic [DATA_LENGTH-1:0]    prdata,
  output logic                      instruction_load_start,
  output logic                      core_select,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

`ifdef LOADER_READBACK_EN
  typedef enum logic [3:0] {
    IDLE, ARM, WAIT_DATA, SETUP, ACCESS, RB_SETUP, RB_ACCESS, RB_CHECK, FINISH
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_DATA, SETUP, ACCESS, FINISH
  } state_t;
`endif

  state_t state, next_state;

  logic [ADDRESS_LENGTH-1:0] addr_q;
  logic [15:0]               remaining;
  logic [3:0]                acc_cnt;
  logic                      acc_last;
  logic                      advance;
  logic                      last_word;

  assign acc_last  = (acc_cnt == 4'(ACCESS_CYCLES - 1));
  assign last_word = (remaining == 16'd1);

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    pselect    = 1'b0;
    pwrite     = 1'b0;
    pready     = 1'b0;
    advance    = 1'b0;
    case (state)
      // done is high in the first IDLE cycle after a load; a start then is dropped
      IDLE:      if (start && !done) next_state = ARM;
      ARM:       next_state = (remaining == 16'd0) ? FINISH : WAIT_DATA;
      WAIT_DATA: begin
        s_ready = 1'b1;
        if (s_valid) next_state = SETUP;
      end
      SETUP: begin
        pselect    = 1'b1;
        pwrite     = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        pselect = 1'b1;
        pwrite  = 1'b1;
        pready  = 1'b1;
        if (acc_last) begin
`ifdef LOADER_READBACK_EN
          next_state = RB_SETUP;
`else
          advance    = 1'b1;
          next_state = last_word ? FINISH : WAIT_DATA;
`endif
        end
      end
`ifdef LOADER_READBACK_EN
      RB_SETUP: begin
        pselect    = 1'b1;
        next_state = RB_ACCESS;
      end
      RB_ACCESS: begin
        pselect = 1'b1;
        pready  = 1'b1;
        if (acc_last) next_state = RB_CHECK;
      end
      RB_CHECK: begin
        advance    = 1'b1;
        next_state = last_word ? FINISH : WAIT_DATA;
      end
`endif
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= IDLE;
      addr_q                 <= '0;
      remaining              <= '0;
      acc_cnt                <= '0;
      paddr                  <= '0;
      pwdata                 <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      core_select            <= 1'b0;
      instruction_load_start <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          addr_q      <= {base_addr[ADDRESS_LENGTH-1:2], 2'b00};
          remaining   <= word_count;
          core_select <= 1'b0;
          busy        <= 1'b1;
        end
        ARM: instruction_load_start <= 1'b1;
        // paddr is loaded on the way into SETUP so it is valid for the whole transfer
        WAIT_DATA: if (s_valid) begin
          pwdata <= s_data;
          paddr  <= addr_q;
        end
        FINISH: begin
          done                   <= 1'b1;
          core_select            <= 1'b1;
          busy                   <= 1'b0;
          instruction_load_start <= 1'b0;
        end
        default: ;
      endcase
      if (pready) acc_cnt <= acc_last ? '0 : acc_cnt + 4'd1;
      else        acc_cnt <= '0;
      if (advance) begin
        remaining <= remaining - 16'd1;
        addr_q    <= addr_q + ADDRESS_LENGTH'(4);
      end
    end
  end

`ifdef LOADER_READBACK_EN
  logic [DATA_LENGTH-1:0] rdata_q;
  logic                   error_q;
  logic                   unused_bits;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == IDLE && start && !done) error_q <= 1'b0;
      if (state == RB_ACCESS && acc_last)  rdata_q <= prdata;
      if (state == RB_CHECK && rdata_q != pwdata) error_q <= 1'b1;
    end
  end

  assign error       = error_q;
  assign unused_bits = ^base_addr[1:0];
`else
  logic unused_bits;
  assign error       = 1'b0;
  assign unused_bits = ^{prdata, base_addr[1:0]};
`endif

endmodule

// File: tb/tb_apb_program_loader.sv
// Directed bench for apb_program_loader (default build, ACCESS_CYCLES=1).
module tb_apb_program_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready;
  logic [31:0] base_addr, s_data, paddr, pwdata, prdata;
  logic [15:0] word_count;
  logic        pselect, pwrite, pready, ils, core_select, busy, done, error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  apb_program_loader #(.DATA_LENGTH(32), .ADDRESS_LENGTH(32), .ACCESS_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .paddr(paddr), .pwdata(pwdata),
    .pselect(pselect), .pwrite(pwrite), .pready(pready), .prdata(prdata),
    .instruction_load_start(ils), .core_select(core_select), .busy(busy), .done(done),
    .error(error)
  );

  // Bus monitor: logs every write access phase, counts selected cycles.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          psel_cycles = 0;
  int          ils_bad     = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (pselect) psel_cycles++;
      if (pselect && !ils) ils_bad++;
      if (pselect && pwrite && pready) begin
        wr_addr_q.push_back(paddr);
        wr_data_q.push_back(pwdata);
      end
    end
  end

  typedef struct {
    logic [31:0] base;
    int          count;
    int          stall_at;
    int          stall_len;
    int          busy_start_cyc;
    bit          start_on_done;
    int          exp_lat;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t        vecs[5];
  vec_t        restart_vec;
  logic [31:0] words[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic run_load(input vec_t v);
    int          off, poff, cyc, idx, stall_cnt;
    bit          seen, hs;
    logic [31:0] a;
    off        = wr_addr_q.size();
    poff       = psel_cycles;
    base_addr  = v.base;
    word_count = 16'(v.count);
    s_valid    = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    idx   = 0;
    seen  = 1'b0;
    stall_cnt = v.stall_len;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    while (!seen && cyc < 200) begin
      s_valid = (idx < v.count) && !(idx == v.stall_at && stall_cnt > 0);
      s_data  = (idx < 4) ? words[idx] : 32'h0;
      if (idx == v.stall_at && stall_cnt > 0 && s_ready) stall_cnt--;
      hs = s_valid && s_ready;
      if (cyc == v.busy_start_cyc) begin
        start      = 1'b1;
        base_addr  = 32'h40;
        word_count = 16'd9;
      end
      tick();
      cyc++;
      start = 1'b0;
      if (hs) idx++;
      if (done) seen = 1'b1;
    end
    s_valid = 1'b0;
    check("done_seen", {31'b0, seen}, 32'd1);
    check("done_latency", cyc, v.exp_lat);
    check("core_select_at_done", {31'b0, core_select}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("ils_at_done", {31'b0, ils}, 32'd0);
    check("error_clear", {31'b0, error}, 32'd0);
    check("write_count", wr_addr_q.size() - off, v.count);
    check("psel_cycles", psel_cycles - poff, 2 * v.count);
    for (int i = 0; i < v.count && off + i < wr_addr_q.size(); i++) begin
      a = {v.base[31:2], 2'b00} + 32'(4 * i);
      check("write_addr", wr_addr_q[off + i], a);
      check("write_data", wr_data_q[off + i], words[i]);
    end
    if (v.count > 0 && wr_addr_q.size() > 0)
      check("last_addr", wr_addr_q[wr_addr_q.size() - 1], v.exp_last_addr);
    if (v.start_on_done) begin
      start      = 1'b1;
      word_count = 16'd5;
      tick();
      start = 1'b0;
      check("start_on_done_ignored", {31'b0, busy}, 32'd0);
    end else begin
      tick();
    end
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("core_select_held", {31'b0, core_select}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, cyc, done_cnt;
    words[0] = 32'h00500093;
    words[1] = 32'h00A00113;
    words[2] = 32'h002081B3;
    words[3] = 32'h12345678;
    //          base          cnt stall len bsc  sod lat last
    vecs[0] = '{32'h00000000, 3, -1, 0, -1, 1'b0, 12, 32'h00000008};
    vecs[1] = '{32'h00001000, 0, -1, 0, -1, 1'b1,  3, 32'h00000000};
    vecs[2] = '{32'h00000100, 3,  1, 5, -1, 1'b0, 17, 32'h00000108};
    vecs[3] = '{32'hFFFFFFFC, 2, -1, 0,  4, 1'b0,  9, 32'h00000000};
    vecs[4] = '{32'h00000203, 1, -1, 0, -1, 1'b0,  6, 32'h00000200};
    restart_vec = '{32'h00000080, 2, -1, 0, -1, 1'b0, 9, 32'h00000084};

    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    base_addr = '0; word_count = '0; prdata = '0;
    tick();
    tick();
    check("rst_pselect", {31'b0, pselect}, 32'd0);
    check("rst_pwrite", {31'b0, pwrite}, 32'd0);
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_pwdata", pwdata, 32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_ils", {31'b0, ils}, 32'd0);
    check("rst_core_select", {31'b0, core_select}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Abort: reset during the access phase of word 2 of 4.
    base_addr  = 32'h0;
    word_count = 16'd4;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA5A5A5A5;
    acc = 0;
    cyc = 0;
    while (acc < 2 && cyc < 100) begin
      tick();
      cyc++;
      if (pselect && pready) acc++;
    end
    check("abort_reached_word2", acc, 2);
    rst = 1'b0;
    tick();
    s_valid = 1'b0;
    check("abort_pselect", {31'b0, pselect}, 32'd0);
    check("abort_ils", {31'b0, ils}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_core_select", {31'b0, core_select}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_paddr", paddr, 32'd0);
    rst = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", {31'b0, busy}, 32'd0);
    run_load(restart_vec);

    check("ils_covers_pselect", ils_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_program_loader.md
# apb_program_loader

APB initiator that loads a RISC-V program image into the core's instruction memory through the core's APB slave port. It takes a stream of 32-bit instruction words, issues one APB write per word at word-aligned, incrementing addresses, and gates the memory path with `instruction_load_start` for the whole load. When the image is complete it releases the core by asserting `core_select`. It sits in the SoC top, directly driving the core's `addr_in`, `data_in`, `pselect`, `pwrite`, `pready` and `instruction_load_start` inputs, and observing `data_out`.

## Interface
- `DATA_LENGTH`, 32: APB data width.
- `ADDRESS_LENGTH`, 32: APB address width.
- `ACCESS_CYCLES`, 1: cycles `pready` is held high per access phase. Legal range 1–15.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load. Ignored while `busy`=1.
- `base_addr` in ADDRESS_LENGTH: first write address, sampled on `start`. Bits [1:0] are forced to 0.
- `word_count` in 16: number of words to load, sampled on `start`.
- `s_valid` in 1: instruction word valid.
- `s_data` in DATA_LENGTH: instruction word.
- `s_ready` out 1: loader accepts `s_data`.
- `paddr` out ADDRESS_LENGTH: to core `addr_in`.
- `pwdata` out DATA_LENGTH: to core `data_in`.
- `pselect` out 1: to core `pselect`.
- `pwrite` out 1: to core `pwrite`.
- `pready` out 1: access-phase strobe, to core `pready`. In this APB variant the initiator drives it.
- `prdata` in DATA_LENGTH: from core `data_out`.
- `instruction_load_start` out 1: routes the APB path to instruction memory.
- `core_select` out 1: core release.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse when a load completes.
- `error` out 1: sticky read-back mismatch flag. Driven only when read-back is compiled in; otherwise tied to 0.

## Operation
- FSM states: IDLE, ARM, WAIT_DATA, SETUP, ACCESS, RB_SETUP, RB_ACCESS, RB_CHECK, FINISH. The three RB_* states exist only with the macro.
- **IDLE**
  - On `start`: latch `base_addr` into `addr_q` and `word_count` into `remaining`.
  - Clear `core_select` and `error`, set `busy`.
  - Go to ARM.
- **ARM** (1 cycle)
  - Assert `instruction_load_start`.
  - If `remaining`==0, go to FINISH; otherwise go to WAIT_DATA.
- **WAIT_DATA**
  - `s_ready`=1.
  - On `s_valid && s_ready`: capture `s_data` into `pwdata` and go to SETUP.
- **SETUP** (1 cycle)
  - `pselect`=1, `pwrite`=1, `pready`=0.
  - `paddr`=`addr_q`, `pwdata` held.
- **ACCESS** (ACCESS_CYCLES cycles)
  - `pselect`=1, `pwrite`=1, `pready`=1.
  - `paddr` and `pwdata` stay stable.
  - On the last access cycle: with read-back, go to RB_SETUP. Without read-back, decrement `remaining`, add 4 to `addr_q`, then go to FINISH if `remaining` becomes 0, else to WAIT_DATA.
- **RB_SETUP / RB_ACCESS**
  - Same phasing as SETUP/ACCESS at the same address, with `pwrite`=0.
  - `prdata` is sampled on the last RB_ACCESS cycle.
- **RB_CHECK** (1 cycle)
  - If the sampled `prdata` != `pwdata`, set `error`.
  - Then do the advance/decrement step described for ACCESS.
- **FINISH** (1 cycle)
  - Deassert `instruction_load_start`.
  - Pulse `done`, set `core_select`=1, clear `busy`.
  - Return to IDLE.
- Address arithmetic is modulo 2^ADDRESS_LENGTH; wrap-around is silent.
- Outside SETUP/ACCESS/RB_*, `pselect`=`pwrite`=`pready`=0, and `paddr`/`pwdata` hold their last value.
- `start` arriving while `busy`=1 is ignored. `start` in the same cycle as `done` is also ignored.
- `s_valid` low in WAIT_DATA stalls indefinitely with no bus activity.

## Timing
- Reset values: all outputs 0, including `core_select`=0, `busy`=0 and `error`=0. FSM returns to IDLE.
- Reset asserted mid-transfer aborts the load on the next edge and drops `instruction_load_start` and `pselect` immediately. There is no partial-completion `done`.
- `start` at edge 0 gives `busy`=1 after edge 0 and `instruction_load_start`=1 after edge 1.
- Per word, with `s_valid` held high:
  - Without read-back: 1 (WAIT_DATA) + 1 (SETUP) + ACCESS_CYCLES cycles.
  - With read-back: add 1 + ACCESS_CYCLES + 1.
- `word_count`=0: `done` pulses 3 cycles after `start` (IDLE→ARM→FINISH), with no APB transfer.
- `instruction_load_start` is high from ARM through the last ACCESS/RB_CHECK cycle inclusive, so it covers every transfer.

## Configuration
- `LOADER_READBACK_EN`
  - Defined: each write is followed by a read-back of the same address and a compare. A mismatch sets sticky `error`; the load still continues.
  - Undefined: RB_* states and compare logic are absent, and `error` is constant 0.

## Test plan
- **Basic load.** `base_addr`=0x0, `word_count`=3, stream 0x00500093, 0x00A00113, 0x002081B3 with `s_valid` held high, ACCESS_CYCLES=1 -> writes to 0x0, 0x4, 0x8 in order; `done` 12 cycles after `start`; `core_select`=1 afterward.
- **Zero-length load.** `word_count`=0 -> no `pselect` activity; `done` 3 cycles after `start`; `core_select`=1.
- **Stalled stream.** `s_valid` low for 5 cycles between words 1 and 2 -> `pselect` stays 0 throughout the gap; addresses and data unchanged.
- **Abort and restart.** Reset pulsed during ACCESS of word 2 of 4 -> all outputs 0 next cycle, `core_select`=0, no `done`; a new `start` then loads cleanly from its own `base_addr`.
- **Wrap and busy-start.** `base_addr`=0xFFFFFFFC, 2 words -> second write goes to 0x00000000. `start` pulsed while `busy` -> ignored.
- **Read-back** (`LOADER_READBACK_EN`). A memory model corrupts word 2 to 0xDEADBEEF -> `error`=1 after RB_CHECK of word 2, load completes, `error` stays 1 until the next `start`.
